inst_buffer: RTL and testbench

//  Circular instruction queue between the fetch stage and the DECODE_WIDTH parallel decoders.
//  - Accepts one fetch bundle per cycle: up to FETCH_WIDTH instructions with a slot-valid mask.

---
 rtl/inst_buffer.sv | 107 ++++++++++
 tb/tb_inst_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and the parallel decoders.
// Accepts one fetch bundle per cycle and compacts its valid slots in slot order.
// It presents up to DECODE_WIDTH of the oldest instructions in program order.
// Ports:
//   clk, rst (async active-low), flush
//   in_valid / in_ready / in_mask / in_inst / in_pc : fetch bundle
//   out_valid / out_inst / out_pc / out_ready       : decode lanes (lane 0 oldest)
//   count                                           : occupied entries
module inst_buffer #(
  parameter int unsigned FETCH_WIDTH  = 4,
  parameter int unsigned DECODE_WIDTH = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PC_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [FETCH_WIDTH-1:0]           in_mask,
  input  logic [FETCH_WIDTH*32-1:0]        in_inst,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]  in_pc,
  output logic [DECODE_WIDTH-1:0]          out_valid,
  output logic [DECODE_WIDTH*32-1:0]       out_inst,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0] out_pc,
  input  logic                             out_ready,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = 32;

  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [IW-1:0]       r_inst [DEPTH];
  logic [PC_WIDTH-1:0] r_pc   [DEPTH];

  logic [CW-1:0] w_pos [FETCH_WIDTH];
  logic [CW-1:0] w_n_in;
  logic [CW-1:0] w_n_out;
  logic [CW-1:0] w_n_in_acc;
  logic [CW-1:0] w_n_out_acc;
  logic          w_enq;
  logic          w_deq;

  // Compaction: each set slot's offset is the number of set slots below it.
  always_comb begin
    w_n_in = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_pos[i] = w_n_in;
      if (in_mask[i]) w_n_in = w_n_in + CW'(1);
    end
  end

  // in_ready deliberately ignores a same-cycle dequeue so it depends on state only.
  assign in_ready    = (r_count <= CW'(DEPTH - FETCH_WIDTH));
  assign w_enq       = in_valid & in_ready & ~flush;
  assign w_deq       = out_ready & ~flush;
  assign w_n_out     = (r_count >= CW'(DECODE_WIDTH)) ? CW'(DECODE_WIDTH) : r_count;
  assign w_n_in_acc  = w_enq ? w_n_in  : '0;
  assign w_n_out_acc = w_deq ? w_n_out : '0;
  assign count       = r_count;

  // Read window: lane j shows entry head+j; pointer arithmetic wraps mod DEPTH.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      out_valid[j]                   = (r_count > CW'(j));
      out_inst[IW*j +: IW]           = r_inst[r_head + AW'(j)];
      out_pc[PC_WIDTH*j +: PC_WIDTH] = r_pc[r_head + AW'(j)];
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (in_mask[i]) begin
          r_inst[r_tail + AW'(w_pos[i])] <= in_inst[IW*i +: IW];
          r_pc[r_tail + AW'(w_pos[i])]   <= in_pc[PC_WIDTH*i +: PC_WIDTH];
        end
      end
    end
  end

  // Pointer and occupancy state; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_n_out_acc);
      r_tail  <= r_tail + AW'(w_n_in_acc);
      r_count <= r_count + w_n_in_acc - w_n_out_acc;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model, a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_inst_buffer;

  localparam int unsigned FW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [FW-1:0]   in_mask;
  logic [FW*32-1:0] in_inst;
  logic [FW*PW-1:0] in_pc;
  logic [DW-1:0]   out_valid;
  logic [DW*32-1:0] out_inst;
  logic [DW*PW-1:0] out_pc;
  logic            out_ready;
  logic [4:0]      count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] g_pc = 32'h8000_0000;

  // Model: queue of {pc, inst}, front = oldest.
  logic [63:0] mq[$];

  inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model update: whole bundle semantics, not pointer arithmetic.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      int sz;
      bit acc;
      sz  = mq.size();
      acc = in_valid && ((DEPTH - sz) >= FW);
      if (out_ready) begin
        for (int k = 0; k < DW && k < sz; k++) void'(mq.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < FW; i++)
          if (in_mask[i]) mq.push_back({in_pc[PW*i +: PW], in_inst[32*i +: 32]});
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      logic [DW-1:0] ev;
      ev = '0;
      for (int j = 0; j < DW; j++) ev[j] = (j < mq.size());
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= FW));
      chk("out_valid", 64'(out_valid), 64'(ev));
      for (int j = 0; j < DW; j++)
        if (j < mq.size())
          chk($sformatf("lane%0d", j), {out_pc[PW*j +: PW], out_inst[32*j +: 32]}, mq[j]);
    end
  end

  task automatic make_bundle();
    for (int i = 0; i < FW; i++) begin
      in_inst[32*i +: 32] = $urandom;
      in_pc[PW*i +: PW]   = g_pc + 32'(4 * i);
    end
    g_pc = g_pc + 32'(4 * FW);
  endtask

  task automatic step(input logic v, input logic [FW-1:0] m, input logic r, input logic f);
    in_valid  = v;
    in_mask   = m;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic [31:0] prev_pc;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mask = '0;
    in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: one full bundle
    for (int i = 0; i < FW; i++) begin
      in_inst[32*i +: 32] = 32'h13 + 32'(i);
      in_pc[PW*i +: PW]   = 32'h8000_0000 + 32'(4 * i);
    end
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    chk("t1_count", 64'(count), 64'd4);
    chk("t1_valid", 64'(out_valid), 64'hF);
    chk("t1_inst0", 64'(out_inst[31:0]), 64'h13);
    chk("t1_pc0", 64'(out_pc[31:0]), 64'h8000_0000);
    chk("t1_pc3", 64'(out_pc[127:96]), 64'h8000_000C);
    step(1'b0, 4'b0, 1'b0, 1'b1);

    // 2: compaction
    make_bundle();
    in_inst[63:32]  = 32'hAAAA_0013;
    in_inst[127:96] = 32'hBBBB_0013;
    step(1'b1, 4'b1010, 1'b0, 1'b0);
    chk("t2_valid", 64'(out_valid), 64'h3);
    chk("t2_lane0", 64'(out_inst[31:0]), 64'hAAAA_0013);
    chk("t2_lane1", 64'(out_inst[63:32]), 64'hBBBB_0013);
    step(1'b0, 4'b0, 1'b0, 1'b1);

    // 3: full
    for (int b = 0; b < 5; b++) begin
      make_bundle();
      step(1'b1, 4'b1111, 1'b0, 1'b0);
      chk($sformatf("t3_count%0d", b), 64'(count), 64'((b + 1) * 4 > 16 ? 16 : (b + 1) * 4));
    end
    chk("t3_ready_full", 64'(in_ready), 64'd0);
    step(1'b0, 4'b0, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      make_bundle();
      step(1'b1, 4'b1111, 1'b0, 1'b0);
    end
    make_bundle();
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    chk("t3_count13", 64'(count), 64'd13);
    chk("t3_ready13", 64'(in_ready), 64'd0);
    step(1'b0, 4'b0, 1'b0, 1'b1);

    // 4: simultaneous enqueue and dequeue at count 6
    make_bundle();
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    pc_a = g_pc;
    make_bundle();
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    chk("t4_count6", 64'(count), 64'd6);
    make_bundle();
    step(1'b1, 4'b1111, 1'b1, 1'b0);
    chk("t4_count", 64'(count), 64'd6);
    chk("t4_lane0_pc", 64'(out_pc[31:0]), 64'(pc_a));
    chk("t4_lane1_pc", 64'(out_pc[63:32]), 64'(pc_a + 32'd4));
    step(1'b0, 4'b0, 1'b0, 1'b1);

    // 5: wrap through 13 rounds of 3 instructions
    prev_pc = '0;
    for (int r = 0; r < 13; r++) begin
      pc_b = g_pc;
      make_bundle();
      step(1'b1, 4'b0111, 1'b1, 1'b0);
      chk($sformatf("t5_count%0d", r), 64'(count), 64'd3);
      chk($sformatf("t5_pc%0d", r), 64'(out_pc[31:0]), 64'(pc_b));
      if (r > 0) chk($sformatf("t5_order%0d", r), 64'(out_pc[31:0] - prev_pc), 64'd16);
      chk($sformatf("t5_pc2_%0d", r), 64'(out_pc[95:64]), 64'(pc_b + 32'd8));
      prev_pc = out_pc[31:0];
    end
    step(1'b0, 4'b0, 1'b0, 1'b1);

    // 6: flush with count 9 and an in-flight bundle, then async reset
    for (int b = 0; b < 2; b++) begin
      make_bundle();
      step(1'b1, 4'b1111, 1'b0, 1'b0);
    end
    make_bundle();
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    chk("t6_count9", 64'(count), 64'd9);
    make_bundle();
    step(1'b1, 4'b1111, 1'b1, 1'b1);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    chk("t6_not_stored", 64'(count), 64'd0);
    make_bundle();
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    chk("t6_refill", 64'(count), 64'd4);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_count", 64'(count), 64'd0);
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      make_bundle();
      step(($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 39) == 0));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
